// File: rtl/tst_din_regs_mc.sv
// AXI4-Lite control/status block for the multi-channel test data-in path:
// per-channel test enables, live iteration counts and coherent snapshots.
module tst_din_regs_mc #(
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 12,
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned NCH                = 4
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   AWADDR,
  input  logic                            AWVALID,
  output logic                            AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] WSTRB,
  input  logic                            WVALID,
  output logic                            WREADY,
  output logic [1:0]                      BRESP,
  output logic                            BVALID,
  input  logic                            BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   ARADDR,
  input  logic                            ARVALID,
  output logic                            ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   RDATA,
  output logic [1:0]                      RRESP,
  output logic                            RVALID,
  input  logic                            RREADY,
  output logic [NCH-1:0]                  test_en,
  output logic                            snap_pulse,
  input  logic [32*NCH-1:0]               itecnt
);

  localparam int unsigned AW = C_S_AXI_ADDR_WIDTH;
  localparam int unsigned DW = C_S_AXI_DATA_WIDTH;
  localparam int unsigned SW = DW / 8;

  localparam logic [1:0] RD_RESET = 2'd0;
  localparam logic [1:0] RD_IDLE  = 2'd1;
  localparam logic [1:0] RD_DATA  = 2'd2;

  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [31:0] ID_VALUE    = {16'h7D10, 8'(NCH), 8'h02};

  localparam logic [5:0] IDX_ID      = 6'd0;
  localparam logic [5:0] IDX_CTRL    = 6'd8;
  localparam logic [5:0] IDX_CMD     = 6'd9;
  localparam logic [5:0] IDX_SNAPCNT = 6'd10;
  localparam int unsigned IDX_SNAP0  = 16;
  localparam int unsigned IDX_LIVE0  = 32;

  logic [1:0]    rd_state, rd_state_nxt;
  logic          aw_held, w_held;
  logic [AW-1:0] aw_addr_q;
  logic [DW-1:0] w_data_q;
  logic [SW-1:0] w_strb_q;
  logic          bvalid_q;
  logic [1:0]    bresp_q;
  logic [31:0]   rdata_q;
  logic [1:0]    rresp_q;
  logic [NCH-1:0] test_en_q;
  logic [31:0]   snap_q [NCH];
  logic [31:0]   snap_cnt_q;
  logic          snap_pulse_q;

  logic          init_done_c;
  logic          aw_hs_c, w_hs_c, ar_hs_c, commit_c;
  logic [AW-1:0] wr_addr_c;
  logic [DW-1:0] wr_data_c;
  logic [SW-1:0] wr_strb_c;
  logic [5:0]    wr_idx_c, rd_idx_c;
  logic          wr_err_c, wr_ctrl_c, wr_cmd_c;
  logic          snap_c, clr_c;
  logic [NCH-1:0] ctrl_nxt_c;
  logic [31:0]   rd_data_c;
  logic          rd_err_c;
  logic          unused_bits;

  // Readies stay low until the read FSM has left its reset state.
  assign init_done_c = (rd_state != RD_RESET);
  assign AWREADY     = init_done_c & ~aw_held & ~bvalid_q;
  assign WREADY      = init_done_c & ~w_held & ~bvalid_q;
  assign ARREADY     = (rd_state == RD_IDLE);
  assign RVALID      = (rd_state == RD_DATA);
  assign BVALID      = bvalid_q;
  assign BRESP       = bresp_q;
  assign RDATA       = rdata_q;
  assign RRESP       = rresp_q;
  assign test_en     = test_en_q;
  assign snap_pulse  = snap_pulse_q;

  assign aw_hs_c = AWVALID & AWREADY;
  assign w_hs_c  = WVALID & WREADY;
  assign ar_hs_c = ARVALID & ARREADY;

  // Commit in the same cycle as the later of the AW/W handshakes.
  assign commit_c  = (aw_held | aw_hs_c) & (w_held | w_hs_c) & ~bvalid_q;
  assign wr_addr_c = aw_held ? aw_addr_q : AWADDR;
  assign wr_data_c = w_held ? w_data_q : WDATA;
  assign wr_strb_c = w_held ? w_strb_q : WSTRB;
  assign wr_idx_c  = wr_addr_c[7:2];

  assign snap_c = wr_cmd_c & wr_strb_c[0] & wr_data_c[0];
  assign clr_c  = wr_cmd_c & wr_strb_c[0] & wr_data_c[1];

  assign unused_bits = ^{wr_data_c, wr_strb_c, wr_addr_c[1:0], ARADDR[1:0]};

  // Write address decode.
  always_comb begin
    wr_err_c  = 1'b1;
    wr_ctrl_c = 1'b0;
    wr_cmd_c  = 1'b0;
    if (wr_addr_c[AW-1:8] == '0) begin
      case (wr_idx_c)
        IDX_ID, IDX_SNAPCNT: wr_err_c = 1'b0;
        IDX_CTRL: begin
          wr_err_c  = 1'b0;
          wr_ctrl_c = 1'b1;
        end
        IDX_CMD: begin
          wr_err_c = 1'b0;
          wr_cmd_c = 1'b1;
        end
        default: ;
      endcase
      for (int c = 0; c < int'(NCH); c++) begin
        if (wr_idx_c == 6'(IDX_SNAP0 + c) || wr_idx_c == 6'(IDX_LIVE0 + c)) wr_err_c = 1'b0;
      end
    end
  end

  // Byte-lane merge of a CTRL write.
  always_comb begin
    ctrl_nxt_c = test_en_q;
    for (int i = 0; i < int'(NCH); i++) begin
      if (wr_strb_c[i/8]) ctrl_nxt_c[i] = wr_data_c[i];
    end
  end

  // Write channel holding, commit and register side effects.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      aw_held      <= 1'b0;
      w_held       <= 1'b0;
      aw_addr_q    <= '0;
      w_data_q     <= '0;
      w_strb_q     <= '0;
      bvalid_q     <= 1'b0;
      bresp_q      <= RESP_OKAY;
      test_en_q    <= '0;
      snap_cnt_q   <= '0;
      snap_pulse_q <= 1'b0;
      for (int c = 0; c < int'(NCH); c++) snap_q[c] <= '0;
    end else begin
      snap_pulse_q <= 1'b0;
      if (aw_hs_c) begin
        aw_held   <= 1'b1;
        aw_addr_q <= AWADDR;
      end
      if (w_hs_c) begin
        w_held   <= 1'b1;
        w_data_q <= WDATA;
        w_strb_q <= WSTRB;
      end
      if (commit_c) begin
        bvalid_q <= 1'b1;
        bresp_q  <= wr_err_c ? RESP_SLVERR : RESP_OKAY;
        if (wr_ctrl_c) test_en_q <= ctrl_nxt_c;
        if (clr_c) test_en_q <= '0;
        if (snap_c) begin
          snap_pulse_q <= 1'b1;
          snap_cnt_q   <= snap_cnt_q + 32'd1;
          for (int c = 0; c < int'(NCH); c++) snap_q[c] <= itecnt[32*c +: 32];
        end
      end else if (bvalid_q && BREADY) begin
        bvalid_q <= 1'b0;
        aw_held  <= 1'b0;
        w_held   <= 1'b0;
      end
    end
  end

  // Read address decode; LIVE values come straight from itecnt.
  always_comb begin
    rd_data_c = '0;
    rd_err_c  = 1'b1;
    rd_idx_c  = ARADDR[7:2];
    if (ARADDR[AW-1:8] == '0) begin
      case (rd_idx_c)
        IDX_ID: begin
          rd_data_c = ID_VALUE;
          rd_err_c  = 1'b0;
        end
        IDX_CTRL: begin
          rd_data_c = 32'(test_en_q);
          rd_err_c  = 1'b0;
        end
        IDX_CMD: rd_err_c = 1'b0;
        IDX_SNAPCNT: begin
          rd_data_c = snap_cnt_q;
          rd_err_c  = 1'b0;
        end
        default: ;
      endcase
      for (int c = 0; c < int'(NCH); c++) begin
        if (rd_idx_c == 6'(IDX_SNAP0 + c)) begin
          rd_data_c = snap_q[c];
          rd_err_c  = 1'b0;
        end
        if (rd_idx_c == 6'(IDX_LIVE0 + c)) begin
          rd_data_c = itecnt[32*c +: 32];
          rd_err_c  = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) rd_state <= RD_RESET;
    else          rd_state <= rd_state_nxt;
  end

  always_comb begin
    rd_state_nxt = rd_state;
    case (rd_state)
      RD_RESET: rd_state_nxt = RD_IDLE;
      RD_IDLE:  if (ARVALID) rd_state_nxt = RD_DATA;
      RD_DATA:  if (RREADY) rd_state_nxt = RD_IDLE;
      default:  rd_state_nxt = RD_RESET;
    endcase
  end

  // Read data/response captured at the AR handshake.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
    end else if (ar_hs_c) begin
      rdata_q <= rd_data_c;
      rresp_q <= rd_err_c ? RESP_SLVERR : RESP_OKAY;
    end
  end

endmodule

// File: tb/tb_tst_din_regs_mc.sv
// Randomized self-checking bench for tst_din_regs_mc against a register-map model.
module tb_tst_din_regs_mc;

  localparam int NCH = 4;

  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic [11:0] AWADDR;
  logic        AWVALID, AWREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WVALID, WREADY;
  logic [1:0]  BRESP;
  logic        BVALID, BREADY;
  logic [11:0] ARADDR;
  logic        ARVALID, ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RVALID, RREADY;
  logic [NCH-1:0] test_en;
  logic        snap_pulse;
  logic [32*NCH-1:0] itecnt;

  int checks = 0;
  int errors = 0;
  int pulse_cnt = 0;

  // Reference model state
  logic [3:0]  m_en;
  logic [31:0] m_snap [NCH];
  logic [31:0] m_cnt;
  int          m_pulses;

  tst_din_regs_mc #(.C_S_AXI_ADDR_WIDTH(12), .C_S_AXI_DATA_WIDTH(32), .NCH(NCH)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .test_en(test_en), .snap_pulse(snap_pulse), .itecnt(itecnt)
  );

  always #5 ACLK = ~ACLK;

  always @(negedge ACLK) if (snap_pulse === 1'b1) pulse_cnt++;

  task automatic model_reset();
    m_en = '0;
    m_cnt = '0;
    for (int c = 0; c < NCH; c++) m_snap[c] = '0;
  endtask

  task automatic model_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp);
    int off;
    off = int'(a) & 'hFFC;
    resp = 2'b00;
    if (off == 'h20) begin
      if (s[0]) m_en = d[3:0];
    end else if (off == 'h24) begin
      if (s[0] && d[1]) m_en = '0;
      if (s[0] && d[0]) begin
        for (int c = 0; c < NCH; c++) m_snap[c] = itecnt[32*c +: 32];
        m_cnt = m_cnt + 1;
        m_pulses++;
      end
    end else if (!(off == 'h00 || off == 'h28 ||
                   (off >= 'h40 && off < 'h40 + 4*NCH) ||
                   (off >= 'h80 && off < 'h80 + 4*NCH))) begin
      resp = 2'b10;
    end
  endtask

  task automatic model_read(input logic [11:0] a, output logic [31:0] d, output logic [1:0] resp);
    int off;
    off = int'(a) & 'hFFC;
    d = '0;
    resp = 2'b00;
    if (off == 'h00) d = 32'h7D10_0402;
    else if (off == 'h20) d = 32'(m_en);
    else if (off == 'h24) d = '0;
    else if (off == 'h28) d = m_cnt;
    else if (off >= 'h40 && off < 'h40 + 4*NCH) d = m_snap[(off - 'h40) / 4];
    else if (off >= 'h80 && off < 'h80 + 4*NCH) d = itecnt[32*((off - 'h80) / 4) +: 32];
    else resp = 2'b10;
  endtask

  // AXI write with independent AW/W start delays; b_lat counts cycles past the last handshake.
  task automatic axi_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_dly, input int w_dly,
                           output logic [1:0] resp, output int b_lat);
    bit aw_done, w_done, early_b;
    int cyc;
    aw_done = 0; w_done = 0; early_b = 0; cyc = 0;
    @(negedge ACLK);
    AWADDR = a; WDATA = d; WSTRB = s;
    while (!(aw_done && w_done) && cyc < 100) begin
      AWVALID = !aw_done && cyc >= aw_dly;
      WVALID  = !w_done && cyc >= w_dly;
      #1;
      if (BVALID) early_b = 1;
      if (AWVALID && AWREADY) aw_done = 1;
      if (WVALID && WREADY) w_done = 1;
      @(negedge ACLK);
      cyc++;
    end
    AWVALID = 0; WVALID = 0; BREADY = 1;
    #1;
    checks++;
    if (early_b || !(aw_done && w_done)) begin
      errors++;
      $display("FAIL write_handshake a=%h: early_b=%0d aw=%0d w=%0d, required 0 1 1", a, early_b, aw_done, w_done);
    end
    b_lat = 0;
    while (!BVALID && b_lat < 20) begin
      @(negedge ACLK); #1; b_lat++;
    end
    resp = BRESP;
    @(negedge ACLK);
    BREADY = 0;
  endtask

  // AXI read; r_lat counts cycles between the AR handshake edge and RVALID being seen.
  task automatic axi_read(input logic [11:0] a, output logic [31:0] data, output logic [1:0] resp,
                          output int r_lat);
    int n;
    @(negedge ACLK);
    ARADDR = a; ARVALID = 1;
    #1;
    n = 0;
    while (!ARREADY && n < 50) begin
      @(negedge ACLK); #1; n++;
    end
    @(negedge ACLK);
    ARVALID = 0;
    #1;
    r_lat = 0;
    while (!RVALID && r_lat < 20) begin
      @(negedge ACLK); #1; r_lat++;
    end
    data = RDATA; resp = RRESP; RREADY = 1;
    @(negedge ACLK);
    RREADY = 0;
  endtask

  // Read a register and compare with the model.
  task automatic read_cmp(input logic [11:0] a, input string name);
    logic [31:0] d, ed;
    logic [1:0] r, er;
    int lat;
    axi_read(a, d, r, lat);
    model_read(a, ed, er);
    checks++;
    if (d !== ed || r !== er || lat != 0) begin
      errors++;
      $display("FAIL %s a=%h: got data=%h resp=%b lat=%0d, required data=%h resp=%b lat=0",
               name, a, d, r, lat, ed, er);
    end
  endtask

  task automatic write_cmp(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_dly, input int w_dly, input string name);
    logic [1:0] r, er;
    int lat;
    axi_write(a, d, s, aw_dly, w_dly, r, lat);
    model_write(a, d, s, er);
    checks++;
    if (r !== er || lat != 0 || test_en !== m_en) begin
      errors++;
      $display("FAIL %s a=%h: got resp=%b lat=%0d test_en=%h, required resp=%b lat=0 test_en=%h",
               name, a, r, lat, test_en, er, m_en);
    end
  endtask

  task automatic check_readies(input logic exp, input string name);
    checks++;
    if (AWREADY !== exp || WREADY !== exp || ARREADY !== exp) begin
      errors++;
      $display("FAIL %s: got aw/w/ar ready=%b%b%b, required %b", name, AWREADY, WREADY, ARREADY, exp);
    end
  endtask

  task automatic release_reset(input string name);
    repeat (2) @(posedge ACLK);
    #1 ARESETN = 1;
    @(negedge ACLK); #1;
    check_readies(1'b0, {name, "_ready_cycle1"});
    @(negedge ACLK); #1;
    check_readies(1'b1, {name, "_ready_cycle2"});
  endtask

  task automatic test_reset();
    @(negedge ACLK);
    ARESETN = 0;
    #1;
    checks++;
    if (test_en !== 4'h0 || snap_pulse !== 1'b0 || BVALID !== 1'b0 || RVALID !== 1'b0 ||
        RDATA !== 32'h0 || BRESP !== 2'b00 || RRESP !== 2'b00) begin
      errors++;
      $display("FAIL reset_outputs: got en=%h sp=%b bv=%b rv=%b rd=%h br=%b rr=%b, required all 0",
               test_en, snap_pulse, BVALID, RVALID, RDATA, BRESP, RRESP);
    end
    check_readies(1'b0, "reset_readies");
    model_reset();
    release_reset("reset");
    read_cmp(12'h000, "read_id");
    read_cmp(12'h020, "read_ctrl_reset");
    read_cmp(12'h028, "read_snapcnt_reset");
    read_cmp(12'h048, "read_snap2_reset");
  endtask

  task automatic test_ctrl();
    write_cmp(12'h020, 32'hF, 4'h1, 3, 0, "ctrl_w_first");
    write_cmp(12'h020, 32'h0, 4'h0, 0, 0, "ctrl_strb0");
    write_cmp(12'h022, 32'h5, 4'h1, 0, 4, "ctrl_aw_first");
    for (int i = 0; i < 8; i++) begin
      write_cmp(12'h020, $urandom, 4'($urandom), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), "ctrl_rand");
      read_cmp(12'h020, "ctrl_readback");
    end
  endtask

  task automatic test_snapshot();
    int p0;
    for (int c = 0; c < NCH; c++) itecnt[32*c +: 32] = $urandom;
    itecnt[64 +: 32] = 32'h1234;
    p0 = pulse_cnt;
    write_cmp(12'h024, 32'h1, 4'h1, 0, 0, "snap_cmd");
    itecnt[64 +: 32] = 32'h5678;
    read_cmp(12'h048, "snap2");
    read_cmp(12'h088, "live2");
    read_cmp(12'h028, "snapcnt");
    read_cmp(12'h024, "cmd_reads0");
    checks++;
    if (pulse_cnt - p0 != 1) begin
      errors++;
      $display("FAIL snap_pulse_count: got %0d, required 1", pulse_cnt - p0);
    end
    for (int c = 0; c < NCH; c++) begin
      itecnt[32*c +: 32] = $urandom;
      read_cmp(12'(32'h40 + 4*c), "snap_other");
      read_cmp(12'(32'h80 + 4*c), "live_other");
    end
  endtask

  task automatic test_unmapped();
    read_cmp(12'h050, "rd_unmapped_50");
    write_cmp(12'h090, 32'hFFFF_FFFF, 4'hF, 0, 0, "wr_unmapped_90");
    write_cmp(12'h120, 32'h0, 4'hF, 1, 0, "wr_unmapped_hi");
    read_cmp(12'h100, "rd_unmapped_hi");
    write_cmp(12'h000, 32'h0, 4'hF, 0, 0, "wr_ro_id");
    write_cmp(12'h028, 32'h0, 4'hF, 0, 0, "wr_ro_snapcnt");
    read_cmp(12'h000, "id_after_unmapped");
    read_cmp(12'h028, "snapcnt_after_unmapped");
    read_cmp(12'h020, "ctrl_after_unmapped");
  endtask

  task automatic test_clr();
    int p0;
    write_cmp(12'h020, 32'hF, 4'h1, 0, 0, "clr_setup");
    write_cmp(12'h024, 32'h3, 4'h0, 0, 0, "cmd_strb0");
    p0 = pulse_cnt;
    write_cmp(12'h024, 32'h3, 4'h1, 0, 0, "cmd_snap_clr");
    read_cmp(12'h028, "snapcnt_after_clr");
    write_cmp(12'h020, 32'hA, 4'h1, 0, 0, "clr_setup2");
    write_cmp(12'h024, 32'h2, 4'h1, 0, 0, "cmd_clr_only");
    checks++;
    if (pulse_cnt - p0 != 1) begin
      errors++;
      $display("FAIL clr_pulse_count: got %0d, required 1", pulse_cnt - p0);
    end
  endtask

  task automatic test_back_to_back();
    int p0, n;
    p0 = pulse_cnt;
    n = 5;
    for (int i = 0; i < n; i++) begin
      itecnt[0 +: 32] = $urandom;
      write_cmp(12'h024, 32'h1, 4'h1, 0, 0, "b2b_snap");
    end
    checks++;
    if (pulse_cnt - p0 != n) begin
      errors++;
      $display("FAIL b2b_pulses: got %0d, required %0d", pulse_cnt - p0, n);
    end
    read_cmp(12'h028, "b2b_snapcnt");
    read_cmp(12'h040, "b2b_snap0");
  endtask

  task automatic test_concurrent();
    logic [31:0] d;
    logic [1:0]  r, br, ebr;
    int rl, bl;
    logic [3:0] old_en, new_en;
    old_en = m_en;
    new_en = ~old_en;
    fork
      axi_write(12'h020, 32'(new_en), 4'h1, 0, 0, br, bl);
      axi_read(12'h020, d, r, rl);
    join
    model_write(12'h020, 32'(new_en), 4'h1, ebr);
    checks++;
    if (d !== 32'(old_en) || r !== 2'b00 || br !== ebr || test_en !== m_en) begin
      errors++;
      $display("FAIL concurrent_rw: got rd=%h rr=%b br=%b en=%h, required rd=%h rr=00 br=%b en=%h",
               d, r, br, test_en, old_en, ebr, m_en);
    end
  endtask

  task automatic test_random();
    logic [11:0] a;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) a = 12'($urandom_range(0, 'h1FF));
      else a = 12'($urandom_range(0, 'h9F));
      if ($urandom_range(0, 1) == 0) itecnt[32*$urandom_range(0, NCH-1) +: 32] = $urandom;
      if ($urandom_range(0, 1) == 0)
        write_cmp(a, $urandom, 4'($urandom), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)), "rand_write");
      read_cmp(a, "rand_read");
    end
    checks++;
    if (pulse_cnt != m_pulses) begin
      errors++;
      $display("FAIL total_pulses: got %0d, required %0d", pulse_cnt, m_pulses);
    end
  endtask

  task automatic test_reset_mid();
    write_cmp(12'h020, 32'h0, 4'h1, 0, 0, "mid_setup");
    @(negedge ACLK);
    AWADDR = 12'h020; WDATA = 32'h5; WSTRB = 4'h1; AWVALID = 1; WVALID = 1; BREADY = 0;
    ARADDR = 12'h000; ARVALID = 1; RREADY = 0;
    @(negedge ACLK);
    AWVALID = 0; WVALID = 0; ARVALID = 0;
    #1;
    checks++;
    if (BVALID !== 1'b1 || RVALID !== 1'b1 || test_en !== 4'h5) begin
      errors++;
      $display("FAIL mid_outstanding: got bv=%b rv=%b en=%h, required 1 1 5", BVALID, RVALID, test_en);
    end
    repeat (2) @(negedge ACLK);
    #2 ARESETN = 0;
    #1;
    checks++;
    if (BVALID !== 1'b0 || RVALID !== 1'b0 || test_en !== 4'h0) begin
      errors++;
      $display("FAIL mid_reset_drop: got bv=%b rv=%b en=%h, required 0 0 0", BVALID, RVALID, test_en);
    end
    model_reset();
    release_reset("mid");
    read_cmp(12'h028, "mid_snapcnt");
    write_cmp(12'h020, 32'h3, 4'h1, 0, 0, "mid_after_write");
  endtask

  initial begin
    ARESETN = 0;
    AWADDR = '0; AWVALID = 0; WDATA = '0; WSTRB = '0; WVALID = 0; BREADY = 0;
    ARADDR = '0; ARVALID = 0; RREADY = 0;
    itecnt = '0;
    m_pulses = 0;
    model_reset();
    test_reset();
    test_ctrl();
    test_snapshot();
    test_unmapped();
    test_clr();
    test_back_to_back();
    test_concurrent();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "watchdog");
  end

endmodule
